byte_merge_buffer: RTL and testbench

- Downstream consumer of the 4-to-16 byte-select decoder. Takes the 16-bit one-hot byte-lane enable plus one write byte, and merges successive byte writes to the same 16-byte block into a single line buffer.
- Drains the merged line (data + byte mask + tag) to the cache data-array write port through a valid/ready handshake.
- Sits between the CPU-side store path and the 4-way data array, so partial-line stores cost one array write instead of sixteen.

---
 rtl/byte_merge_buffer.sv | 152 +++++++++++++++
 tb/tb_byte_merge_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_merge_buffer.sv
// Byte-write merge buffer: collects byte stores to one 16-byte block and drains the
// merged line (tag, data, mask) over valid/ready. Optional hit counter: BYTE_MERGE_HIT_CNT_EN.
module byte_merge_buffer #(
  parameter int TAG_W   = 28,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [15:0]      byte_en,
  input  logic [7:0]       wr_byte,
  input  logic             flush_req,
  output logic             flush_valid,
  input  logic             flush_ready,
  output logic [TAG_W-1:0] flush_tag,
  output logic [127:0]     flush_data,
  output logic [15:0]      flush_mask
`ifdef BYTE_MERGE_HIT_CNT_EN
  ,
  output logic [15:0]      merge_hits
`endif
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {EMPTY, MERGE, FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [127:0]     line_data_reg, line_data_next, merged_data;
  logic [15:0]      line_mask_reg, line_mask_next;
  logic [TAG_W-1:0] line_tag_reg, line_tag_next;
  logic [CNT_W-1:0] idle_reg, idle_next;
  logic [127:0]     flush_data_reg, flush_data_next;
  logic [15:0]      flush_mask_reg, flush_mask_next;
  logic [TAG_W-1:0] flush_tag_reg, flush_tag_next;
  logic             accept, tag_hit, timeout_hit;

  // Each enabled lane takes the write byte; others keep the current line contents.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
      assign merged_data[8*gi +: 8] = byte_en[gi] ? wr_byte : line_data_reg[8*gi +: 8];
    end
  endgenerate

  assign tag_hit     = (wr_tag == line_tag_reg);
  assign timeout_hit = (TIMEOUT != 0) && (idle_reg == IDLE_LAST);
  assign accept      = wr_valid & wr_ready;

  always_comb begin
    state_next      = state_reg;
    line_data_next  = line_data_reg;
    line_mask_next  = line_mask_reg;
    line_tag_next   = line_tag_reg;
    idle_next       = idle_reg;
    flush_data_next = flush_data_reg;
    flush_mask_next = flush_mask_reg;
    flush_tag_next  = flush_tag_reg;
    wr_ready        = 1'b0;

    case (state_reg)
      EMPTY: begin
        wr_ready = 1'b1;
        if (wr_valid && byte_en != 16'h0000) begin
          line_tag_next  = wr_tag;
          line_data_next = merged_data;
          line_mask_next = byte_en;
          idle_next      = '0;
          state_next     = MERGE;
        end
      end
      MERGE: begin
        wr_ready = !flush_req && !(wr_valid && !tag_hit);
        if (flush_req || (wr_valid && !tag_hit)) begin
          state_next = FLUSH;
        end else begin
          if (wr_valid) begin
            line_data_next = merged_data;
            line_mask_next = line_mask_reg | byte_en;
            idle_next      = '0;
          end else if (!(&idle_reg)) begin
            idle_next = idle_reg + 1'b1;
          end
          if (line_mask_next == 16'hFFFF || (!wr_valid && timeout_hit))
            state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_ready) begin
          line_data_next  = '0;
          line_mask_next  = '0;
          idle_next       = '0;
          flush_data_next = '0;
          flush_mask_next = '0;
          flush_tag_next  = '0;
          state_next      = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase

    // Snapshot the post-write line so the drained copy is stable during backpressure.
    if (state_reg != FLUSH && state_next == FLUSH) begin
      flush_data_next = line_data_next;
      flush_mask_next = line_mask_next;
      flush_tag_next  = line_tag_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= EMPTY;
      line_data_reg  <= '0;
      line_mask_reg  <= '0;
      line_tag_reg   <= '0;
      idle_reg       <= '0;
      flush_data_reg <= '0;
      flush_mask_reg <= '0;
      flush_tag_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      line_data_reg  <= line_data_next;
      line_mask_reg  <= line_mask_next;
      line_tag_reg   <= line_tag_next;
      idle_reg       <= idle_next;
      flush_data_reg <= flush_data_next;
      flush_mask_reg <= flush_mask_next;
      flush_tag_reg  <= flush_tag_next;
    end
  end

  assign flush_valid = (state_reg == FLUSH);
  assign flush_data  = flush_data_reg;
  assign flush_mask  = flush_mask_reg;
  assign flush_tag   = flush_tag_reg;

`ifdef BYTE_MERGE_HIT_CNT_EN
  logic [15:0] hits_reg;

  always_ff @(posedge clk) begin
    if (reset)
      hits_reg <= '0;
    else if (state_reg == MERGE && accept && byte_en != 16'h0000 && hits_reg != 16'hFFFF)
      hits_reg <= hits_reg + 16'd1;
  end

  assign merge_hits = hits_reg;
`endif

endmodule

// File: tb/tb_byte_merge_buffer.sv
// Randomized scoreboard bench for byte_merge_buffer: a per-cycle behavioural model predicts
// wr_ready/flush_valid and queues expected drained lines; a monitor compares on flush_valid.
module tb_byte_merge_buffer;
  localparam int TAG_W = 28;
  localparam int TO    = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [TAG_W-1:0] wr_tag = '0;
  logic [15:0]      byte_en = '0;
  logic [7:0]       wr_byte = '0;
  logic             flush_req = 1'b0;
  logic             flush_valid;
  logic             flush_ready = 1'b0;
  logic [TAG_W-1:0] flush_tag;
  logic [127:0]     flush_data;
  logic [15:0]      flush_mask;
`ifdef BYTE_MERGE_HIT_CNT_EN
  logic [15:0]      merge_hits;
`endif

  byte_merge_buffer #(.TAG_W(TAG_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_tag(wr_tag),
    .byte_en(byte_en), .wr_byte(wr_byte), .flush_req(flush_req),
    .flush_valid(flush_valid), .flush_ready(flush_ready),
    .flush_tag(flush_tag), .flush_data(flush_data), .flush_mask(flush_mask)
`ifdef BYTE_MERGE_HIT_CNT_EN
    , .merge_hits(merge_hits)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [127:0]     data;
    logic [15:0]      mask;
  } line_t;

  line_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: a line is either absent, open for merging, or waiting to drain.
  bit               m_open, m_flushing;
  logic [TAG_W-1:0] m_tag;
  logic [7:0]       m_bytes [16];
  logic [15:0]      m_mask;
  int               m_idle;
  int               m_hits;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_open = 0; m_flushing = 0; m_mask = '0; m_idle = 0;
    for (int i = 0; i < 16; i++) m_bytes[i] = 8'h00;
  endtask

  task automatic model_write(input logic [15:0] be, input logic [7:0] b);
    for (int i = 0; i < 16; i++)
      if (be[i]) begin m_bytes[i] = b; m_mask[i] = 1'b1; end
  endtask

  task automatic model_push();
    line_t e;
    e.tag = m_tag; e.mask = m_mask; e.data = '0;
    for (int i = 0; i < 16; i++) e.data[8*i +: 8] = m_bytes[i];
    q.push_back(e);
    m_flushing = 1;
  endtask

  // One clock of stimulus: drive, check combinational/flag outputs, advance the model.
  task automatic tick(input bit wv, input logic [TAG_W-1:0] tg, input logic [15:0] be,
                      input logic [7:0] b, input bit fq, input bit fr);
    bit exp_rdy, acc, go;
    @(negedge clk);
    wr_valid = wv; wr_tag = tg; byte_en = be; wr_byte = b; flush_req = fq; flush_ready = fr;
    #1;
    exp_rdy = !m_flushing && !(m_open && (fq || (wv && tg != m_tag)));
    acc = wv && exp_rdy;
    check("wr_ready", {127'b0, wr_ready}, {127'b0, exp_rdy});
    check("flush_valid", {127'b0, flush_valid}, {127'b0, m_flushing});
    if (m_flushing) begin
      if (fr) model_clear();
    end else if (!m_open) begin
      if (acc && be != 0) begin
        m_open = 1; m_tag = tg; m_idle = 0;
        model_write(be, b);
      end
    end else begin
      go = 0;
      if (fq || (wv && tg != m_tag)) go = 1;
      else begin
        if (acc) begin
          model_write(be, b);
          m_idle = 0;
          if (be != 0 && m_hits < 65535) m_hits++;
        end else begin
          if (TO != 0 && m_idle == TO - 1) go = 1;
          m_idle++;
        end
        if (m_mask == 16'hFFFF) go = 1;
      end
      if (go) model_push();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; wr_valid = 0; flush_req = 0; flush_ready = 0;
    model_clear();
    q.delete();
    m_hits = 0;
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_flush_valid", {127'b0, flush_valid}, 128'd0);
    check("rst_flush_mask", {112'b0, flush_mask}, 128'd0);
    check("rst_flush_data", flush_data, 128'd0);
    check("rst_flush_tag", {{(128-TAG_W){1'b0}}, flush_tag}, 128'd0);
    check("rst_wr_ready", {127'b0, wr_ready}, 128'd1);
`ifdef BYTE_MERGE_HIT_CNT_EN
    check("rst_merge_hits", {112'b0, merge_hits}, 128'd0);
`endif
  endtask

  // Monitor: whenever a line is presented it must match the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (!reset && flush_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_flush: got tag %0h mask %0h expected no line", flush_tag, flush_mask);
      end else begin
        check("flush_tag", {{(128-TAG_W){1'b0}}, flush_tag}, {{(128-TAG_W){1'b0}}, q[0].tag});
        check("flush_data", flush_data, q[0].data);
        check("flush_mask", {112'b0, flush_mask}, {112'b0, q[0].mask});
        if (flush_ready) begin
          $display("line drained tag=%0h mask=%04h", flush_tag, flush_mask);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [15:0] be;
    logic [TAG_W-1:0] tg;
    int idle_pct;
    m_hits = 0;
    model_clear();
    do_reset();

    // full line, back to back
    for (int i = 0; i < 16; i++) tick(1, 28'h1234, 16'h1 << i, 8'(i), 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);

    // tag conflict with backpressure, held write accepted after handshake
    tick(1, 28'hA, 16'h0008, 8'h55, 0, 0);
    for (int i = 0; i < 6; i++) tick(1, 28'hB, 16'h0001, 8'h77, 0, 0);
    tick(1, 28'hB, 16'h0001, 8'h77, 0, 1);
    tick(1, 28'hB, 16'h0001, 8'h77, 0, 1);
    tick(0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 1);

    // timeout after a single write
    tick(1, 28'h5, 16'h0020, 8'hC3, 0, 0);
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);

    // hits: open + 3 matching + a zero-enable write; then flush_req beats a matching write
    tick(1, 28'h7, 16'h0001, 8'h11, 0, 0);
    tick(1, 28'h7, 16'h0002, 8'h22, 0, 0);
    tick(1, 28'h7, 16'h0000, 8'h99, 0, 0);
    tick(1, 28'h7, 16'h0004, 8'h33, 0, 0);
    tick(1, 28'h7, 16'h0008, 8'h44, 0, 0);
    tick(1, 28'h7, 16'h0010, 8'h55, 1, 0);
`ifdef BYTE_MERGE_HIT_CNT_EN
    check("merge_hits", {112'b0, merge_hits}, 128'(m_hits));
`endif
    tick(0, 0, 0, 0, 0, 0);
    do_reset();

    // random traffic
    idle_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) idle_pct = ($urandom % 3 == 0) ? 95 : (($urandom % 2 == 0) ? 50 : 10);
      case ($urandom % 8)
        0: be = 16'h0000;
        1: be = (16'h1 << ($urandom % 16)) | (16'h1 << ($urandom % 16));
        default: be = 16'h1 << ($urandom % 16);
      endcase
      tg = ($urandom % 4 != 0) ? m_tag : TAG_W'($urandom % 3);
      tick(($urandom % 100) >= idle_pct, tg, be, 8'($urandom), ($urandom % 25) == 0,
           ($urandom % 10) < 7);
    end

    // close any open line and drain
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 1);
    check("drain_queue_empty", 128'(q.size()), 128'd0);
`ifdef BYTE_MERGE_HIT_CNT_EN
    check("merge_hits_final", {112'b0, merge_hits}, 128'(m_hits));
`endif

    // reset while a line waits to drain
    tick(1, 28'h3, 16'h0100, 8'hAB, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
